// File: rtl/img_uart_uploader_pkg.sv
// Shared definitions for the result-upload path: FSM encoding, UART 8N1 frame
// constants and the default baud divider.
package img_uart_uploader_pkg;

  localparam int unsigned DEF_BAUD_DIV    = 434;
  localparam int unsigned UART_DATA_BITS  = 8;
  localparam int unsigned UART_FRAME_BITS = UART_DATA_BITS + 2;
  localparam logic        UART_START_BIT  = 1'b0;
  localparam logic        UART_STOP_BIT   = 1'b1;

  // START/DATA/STOP are carried out by the serializer while the top sits in XMIT.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_WAIT,
    ST_XMIT,
    ST_DONE
  } upl_state_e;

  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/img_uart_uploader_serializer.sv
// 8N1 transmitter: baud counter plus a 10-bit frame shift register.
// Accepts a byte on i_load while ready; o_frame_end flags the last stop-bit cycle.
module uart_tx_serializer
  import img_uart_uploader_pkg::*;
#(
  parameter int unsigned BAUD_DIV = DEF_BAUD_DIV
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_load,
  input  logic [UART_DATA_BITS-1:0] i_data,
  output logic                      o_tx,
  output logic                      o_ready,
  output logic                      o_frame_end
);

  localparam int unsigned BW   = cnt_width(BAUD_DIV);
  localparam int unsigned NW   = cnt_width(UART_FRAME_BITS);
  localparam logic [BW-1:0] BAUD_MAX = BW'(BAUD_DIV - 1);
  localparam logic [NW-1:0] LAST_BIT = NW'(UART_FRAME_BITS - 1);

  logic [UART_FRAME_BITS-1:0] r_frame;
  logic [BW-1:0]              r_baud;
  logic [NW-1:0]              r_bit;
  logic                       r_active;
  logic                       w_bit_end;

  assign w_bit_end = r_active && (r_baud == BAUD_MAX);

  // NOTE: reset is sampled on the clock edge and all state uses non-blocking
  // assignments, so every flop sees pre-edge values regardless of block order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_frame  <= '1;
      r_baud   <= '0;
      r_bit    <= '0;
      r_active <= 1'b0;
    end else if (i_load && !r_active) begin
      r_frame  <= {UART_STOP_BIT, i_data, UART_START_BIT};
      r_baud   <= '0;
      r_bit    <= '0;
      r_active <= 1'b1;
    end else if (r_active) begin
      if (w_bit_end) begin
        // Shift in ones so the line rests high once the stop bit leaves.
        r_baud  <= '0;
        r_frame <= {1'b1, r_frame[UART_FRAME_BITS-1:1]};
        if (r_bit == LAST_BIT) begin
          r_active <= 1'b0;
          r_bit    <= '0;
        end else begin
          r_bit <= r_bit + 1'b1;
        end
      end else begin
        r_baud <= r_baud + 1'b1;
      end
    end
  end

  assign o_tx        = r_frame[0];
  assign o_ready     = !r_active;
  assign o_frame_end = w_bit_end && (r_bit == LAST_BIT);

endmodule

// File: rtl/img_uart_uploader.sv
// Result uploader: on an end_flag rising edge, reads byte_count bytes from the
// output image memory starting at address 0 and sends each one as 8N1 on tx.
module img_uart_uploader
  import img_uart_uploader_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 19,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned BAUD_DIV   = DEF_BAUD_DIV,
  parameter int unsigned MEM_LAT    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  end_flag,
  input  logic [ADDR_WIDTH-1:0] byte_count,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_re,
  input  logic [DATA_WIDTH-1:0] mem_q,
  output logic                  tx,
  output logic                  busy,
  output logic                  led_tx,
  output logic                  done
);

  localparam int unsigned WW = cnt_width(MEM_LAT);
  localparam logic [WW-1:0] WAIT_MAX = WW'(MEM_LAT - 1);

  upl_state_e            r_state, w_next;
  logic                  r_prev;
  logic [ADDR_WIDTH-1:0] r_cnt;
  logic [ADDR_WIDTH-1:0] r_index;
  logic [WW-1:0]         r_wait;

  logic w_trigger, w_wait_last, w_last_byte;
  logic w_load, w_ready, w_frame_end, w_tx;

  assign w_trigger   = end_flag && !r_prev;
  assign w_wait_last = (r_wait == WAIT_MAX);
  assign w_last_byte = (r_index == r_cnt - 1'b1);

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    w_next = r_state;
    w_load = 1'b0;
    case (r_state)
      ST_IDLE:  if (w_trigger) w_next = (byte_count == '0) ? ST_DONE : ST_FETCH;
      ST_FETCH: w_next = ST_WAIT;
      ST_WAIT: begin
        if (w_wait_last && w_ready) begin
          w_load = 1'b1;
          w_next = ST_XMIT;
        end
      end
      ST_XMIT:  if (w_frame_end) w_next = w_last_byte ? ST_DONE : ST_FETCH;
      ST_DONE:  w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_prev  <= end_flag;  // primed so a level already high is not an edge
      r_cnt   <= '0;
      r_index <= '0;
      r_wait  <= '0;
    end else begin
      r_state <= w_next;
      r_prev  <= end_flag;
      if (r_state == ST_IDLE && w_trigger) begin
        r_cnt <= byte_count;
        // A zero-length upload leaves the address untouched.
        if (byte_count != '0) r_index <= '0;
      end
      if (r_state == ST_FETCH) r_wait <= '0;
      else if (r_state == ST_WAIT && !w_wait_last) r_wait <= r_wait + 1'b1;
      if (r_state == ST_XMIT && w_frame_end && !w_last_byte) r_index <= r_index + 1'b1;
    end
  end

  uart_tx_serializer #(
    .BAUD_DIV (BAUD_DIV)
  ) u_ser (
    .clk         (clk),
    .rst         (rst),
    .i_load      (w_load),
    .i_data      (mem_q),
    .o_tx        (w_tx),
    .o_ready     (w_ready),
    .o_frame_end (w_frame_end)
  );

  assign mem_addr = r_index;
  assign mem_re   = (r_state == ST_FETCH);
  assign busy     = (r_state == ST_FETCH) || (r_state == ST_WAIT) || (r_state == ST_XMIT);
  assign led_tx   = busy;
  assign done     = (r_state == ST_DONE);
  assign tx       = w_tx;

endmodule

// File: tb/tb_img_uart_uploader.sv
// Self-checking bench for img_uart_uploader: per-cycle comparison against a
// frame-level model, table-driven uploads, random uploads and corner sequences.
module tb_img_uart_uploader;

  localparam int AW = 19;
  localparam int DW = 8;
  localparam int BD = 4;
  localparam int ML = 1;
  localparam int P  = 10 * BD + ML + 1;  // cycles per byte including the fetch gap

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          end_flag = 1'b1;
  logic [AW-1:0] byte_count = '0;
  logic [AW-1:0] mem_addr;
  logic          mem_re;
  logic [DW-1:0] mem_q;
  logic          tx, busy, led_tx, done;

  always #5 clk = ~clk;

  img_uart_uploader #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .BAUD_DIV   (BD),
    .MEM_LAT    (ML)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .end_flag   (end_flag),
    .byte_count (byte_count),
    .mem_addr   (mem_addr),
    .mem_re     (mem_re),
    .mem_q      (mem_q),
    .tx         (tx),
    .busy       (busy),
    .led_tx     (led_tx),
    .done       (done)
  );

  // Registered-read memory; outside its one valid cycle mem_q carries junk.
  logic [7:0] mem [0:63];
  logic [7:0] r_q = '0;
  logic [7:0] junk = '0;
  logic       r_valid = 1'b0;

  always @(posedge clk) begin
    r_valid <= mem_re;
    if (mem_re) r_q <= mem[mem_addr[5:0]];
  end
  always @(negedge clk) junk <= 8'($urandom);
  assign mem_q = r_valid ? r_q : junk;

  typedef struct packed {
    logic          tx;
    logic          busy;
    logic          led;
    logic          re;
    logic          dn;
    logic [AW-1:0] addr;
  } obs_t;

  typedef struct {
    int             cnt;
    logic [2:0][7:0] d;
    int             exp_done;
    int             exp_reads;
  } vec_t;

  int            total = 0;
  int            bad = 0;
  logic [AW-1:0] exp_addr = '0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", name, got, exp);
    end
  endtask

  function automatic obs_t observe();
    obs_t o;
    o.tx = tx; o.busy = busy; o.led = led_tx; o.re = mem_re; o.dn = done; o.addr = mem_addr;
    return o;
  endfunction

  function automatic obs_t idle_obs(input logic [AW-1:0] a);
    obs_t o;
    o.tx = 1'b1; o.busy = 1'b0; o.led = 1'b0; o.re = 1'b0; o.dn = 1'b0; o.addr = a;
    return o;
  endfunction

  // Expected line/handshake state c cycles after the edge that sees the trigger.
  function automatic obs_t model(input int c, input int n);
    obs_t e;
    int   o, b, i;
    e = idle_obs(exp_addr);
    if (c >= 1 && c <= n * P) begin
      i = (c - 1) / P;
      o = (c - 1) % P;
      e.busy = 1'b1;
      e.led  = 1'b1;
      if (o == 0) begin
        e.re = 1'b1;
        e.addr = AW'(i);
      end else if (o > ML) begin
        b = (o - ML - 1) / BD;
        if (b == 0) e.tx = 1'b0;
        else if (b <= 8) e.tx = mem[i][b-1];
      end
    end else if (c == n * P + 1) begin
      e.dn = 1'b1;
    end
    return e;
  endfunction

  task automatic run_upload(input int n, input int glitch_at, input int bc_at,
                            input int stop_at, input int exp_done, input int exp_reads);
    int   reads = 0;
    int   done_c = -1;
    int   last;
    obs_t e;
    last = (stop_at > 0) ? stop_at : n * P + 4;
    @(negedge clk);
    byte_count = AW'(n);
    end_flag = 1'b1;
    for (int c = 1; c <= last; c++) begin
      @(negedge clk);
      e = model(c, n);
      exp_addr = e.addr;
      check($sformatf("n%0d_cyc%0d", n, c), 32'(observe()), 32'(e));
      if (mem_re) reads++;
      if (done && done_c < 0) done_c = c;
      if (c == glitch_at) end_flag = 1'b0;
      if (c == glitch_at + 2) end_flag = 1'b1;
      if (c == bc_at) byte_count = AW'($urandom_range(1, 200));
    end
    if (exp_done >= 0) begin
      check($sformatf("n%0d_done_cycle", n), 32'(done_c), 32'(exp_done));
      check($sformatf("n%0d_reads", n), 32'(reads), 32'(exp_reads));
    end
  endtask

  vec_t vecs [4];

  initial begin
    vecs[0] = '{cnt: 3, d: {8'h00, 8'hA3, 8'h55}, exp_done: 127, exp_reads: 3};
    vecs[1] = '{cnt: 0, d: {8'h00, 8'h00, 8'h00}, exp_done: 1,   exp_reads: 0};
    vecs[2] = '{cnt: 1, d: {8'h00, 8'h00, 8'hFF}, exp_done: 43,  exp_reads: 1};
    vecs[3] = '{cnt: 2, d: {8'h00, 8'h81, 8'h3C}, exp_done: 85,  exp_reads: 2};
    for (int i = 0; i < 64; i++) mem[i] = 8'($urandom);

    // Reset with end_flag already high: quiet outputs, no upload afterwards.
    rst = 1'b0;
    end_flag = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_state", 32'(observe()), 32'(idle_obs('0)));
    rst = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("post_reset_idle", 32'(observe()), 32'(idle_obs('0)));
    end
    end_flag = 1'b0;

    // Table-driven uploads.
    for (int v = 0; v < 4; v++) begin
      for (int k = 0; k < 3; k++) mem[k] = vecs[v].d[k];
      run_upload(vecs[v].cnt, 0, 0, 0, vecs[v].exp_done, vecs[v].exp_reads);
      end_flag = 1'b0;
    end

    // end_flag dropped and re-raised during byte 1 is ignored; held high after done.
    for (int k = 0; k < 3; k++) mem[k] = 8'($urandom);
    run_upload(3, 5, 0, 0, 127, 3);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("no_retrigger", 32'(observe()), 32'(idle_obs(exp_addr)));
    end
    end_flag = 1'b0;

    // byte_count changed mid-upload; memory data is only valid on its read cycle.
    for (int k = 0; k < 2; k++) mem[k] = 8'($urandom);
    run_upload(2, 0, 10, 0, 85, 2);
    end_flag = 1'b0;

    // Random uploads.
    for (int r = 0; r < 3; r++) begin
      int n;
      n = $urandom_range(1, 4);
      for (int k = 0; k < n; k++) mem[k] = 8'($urandom);
      run_upload(n, 0, 0, 0, n * P + 1, n);
      end_flag = 1'b0;
    end

    // Reset during the data bits of byte 2, then a fresh upload from address 0.
    for (int k = 0; k < 3; k++) mem[k] = 8'($urandom);
    run_upload(3, 0, 0, 1 + P + ML + 1 + 2 * BD, -1, -1);
    rst = 1'b0;
    @(negedge clk);
    check("abort_reset", 32'(observe()), 32'(idle_obs('0)));
    exp_addr = '0;
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("abort_idle", 32'(observe()), 32'(idle_obs('0)));
    end
    end_flag = 1'b0;
    run_upload(3, 0, 0, 0, 127, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
